cpu7_exu_byp: RTL and testbench

- Multi-lane E->M->W result pipeline and operand bypass network for the cpu7 execution unit; parametrised successor to the single-lane, bypass-less EXU datapath.
- Receives per-lane E-stage results from the ALUs and carries them through M and W registers.
- Drives register-file write ports and debug writeback ports, and forwards in-flight results to D-stage operands.
- Detects load-use hazards and raises a decode stall.

---
 rtl/cpu7_exu_byp_pkg.sv | 25 ++
 rtl/cpu7_exu_byp_mux.sv | 43 ++++
 rtl/cpu7_exu_byp.sv | 136 +++++++++++++
 tb/tb_cpu7_exu_byp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_exu_byp_pkg.sv
// Shared definitions for the cpu7 EXU result pipeline and operand bypass network.
package cpu7_exu_byp_pkg;

    localparam int unsigned GRLEN_DEF     = 32;
    localparam int unsigned RF_AW_DEF     = 5;
    localparam int unsigned LANES_DEF     = 2;
    localparam int unsigned SRCS_PER_LANE = 2;

    typedef enum logic [1:0] {
        SrcRf,
        SrcW,
        SrcM,
        SrcE
    } byp_src_e;

    // Nearest in-flight stage wins: E over M over W over the register file.
    function automatic byp_src_e byp_pick(input logic e_any, input logic m_any,
                                          input logic w_any);
        if (e_any) return SrcE;
        if (m_any) return SrcM;
        if (w_any) return SrcW;
        return SrcRf;
    endfunction

endpackage

// File: rtl/cpu7_exu_byp_mux.sv
// One-operand bypass mux: picks the youngest hitting lane of the nearest stage, else RF data.
module cpu7_exu_byp_mux
    import cpu7_exu_byp_pkg::*;
#(
    parameter int unsigned GRLEN = GRLEN_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic [LANES-1:0]       e_hit,
    input  logic [LANES*GRLEN-1:0] e_data,
    input  logic [LANES-1:0]       m_hit,
    input  logic [LANES*GRLEN-1:0] m_data,
    input  logic [LANES-1:0]       w_hit,
    input  logic [LANES*GRLEN-1:0] w_data,
    input  logic [GRLEN-1:0]       rf_data,
    output logic [GRLEN-1:0]       op_data
);

    logic [GRLEN-1:0] e_sel;
    logic [GRLEN-1:0] m_sel;
    logic [GRLEN-1:0] w_sel;
    byp_src_e         src;

    always_comb begin
        e_sel   = '0;
        m_sel   = '0;
        w_sel   = '0;
        op_data = rf_data;
        // Ascending scan so a younger (higher) lane overrides an older one.
        for (int i = 0; i < LANES; i++) begin
            if (e_hit[i]) e_sel = e_data[i*GRLEN +: GRLEN];
            if (m_hit[i]) m_sel = m_data[i*GRLEN +: GRLEN];
            if (w_hit[i]) w_sel = w_data[i*GRLEN +: GRLEN];
        end
        src = byp_pick(|e_hit, |m_hit, |w_hit);
        unique case (src)
            SrcE:  op_data = e_sel;
            SrcM:  op_data = m_sel;
            SrcW:  op_data = w_sel;
            SrcRf: op_data = rf_data;
        endcase
    end

endmodule

// File: rtl/cpu7_exu_byp.sv
// Multi-lane E->M->W result pipeline with D-stage operand forwarding and load-use interlock.
module cpu7_exu_byp
    import cpu7_exu_byp_pkg::*;
#(
    parameter int unsigned GRLEN = GRLEN_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned RF_AW = RF_AW_DEF
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 hold,
    input  logic                                 flush,
    input  logic [LANES-1:0]                     e_valid,
    input  logic [LANES-1:0]                     e_wen,
    input  logic [LANES-1:0]                     e_ld,
    input  logic [LANES*RF_AW-1:0]               e_rd,
    input  logic [LANES*GRLEN-1:0]               e_res,
    input  logic [LANES*GRLEN-1:0]               e_pc,
    input  logic [LANES*GRLEN-1:0]               m_ld_data,
    input  logic [LANES*SRCS_PER_LANE*RF_AW-1:0] d_rs,
    input  logic [LANES*SRCS_PER_LANE*GRLEN-1:0] d_rf_data,
    output logic [LANES*SRCS_PER_LANE*GRLEN-1:0] d_op_data,
    output logic                                 d_stall,
    output logic [LANES-1:0]                     w_wen,
    output logic [LANES*RF_AW-1:0]               w_rd,
    output logic [LANES*GRLEN-1:0]               w_data,
    output logic [LANES*GRLEN-1:0]               w_pc
);

    localparam int unsigned NSRC = LANES * SRCS_PER_LANE;

    logic [LANES-1:0]       m_valid_q, m_wen_q, m_ld_q;
    logic [LANES*RF_AW-1:0] m_rd_q;
    logic [LANES*GRLEN-1:0] m_res_q, m_pc_q, m_data;
    logic [LANES-1:0]       w_valid_q, w_wen_q;
    logic [LANES-1:0]       e_keep, m_keep, w_keep;
    logic [NSRC-1:0]        stall_src;

    // Effective writes of a stage, with older lanes dropped when a younger lane targets the same rd.
    function automatic logic [LANES-1:0] keep_mask(input logic [LANES-1:0]       valid,
                                                   input logic [LANES-1:0]       wen,
                                                   input logic [LANES*RF_AW-1:0] rd);
        logic [LANES-1:0] eff;
        logic [LANES-1:0] keep;
        for (int i = 0; i < LANES; i++) begin
            eff[i] = valid[i] & wen[i] & (rd[i*RF_AW +: RF_AW] != '0);
        end
        keep = eff;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (eff[j] && (rd[j*RF_AW +: RF_AW] == rd[i*RF_AW +: RF_AW])) keep[i] = 1'b0;
            end
        end
        return keep;
    endfunction

    assign e_keep = keep_mask(e_valid, e_wen, e_rd);
    assign m_keep = keep_mask(m_valid_q, m_wen_q, m_rd_q);
    assign w_keep = keep_mask(w_valid_q, w_wen_q, w_rd);
    assign w_wen  = w_keep;

    always_comb begin
        m_data = m_res_q;
        for (int i = 0; i < LANES; i++) begin
            if (m_ld_q[i]) m_data[i*GRLEN +: GRLEN] = m_ld_data[i*GRLEN +: GRLEN];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_q <= '0;
            m_wen_q   <= '0;
            m_ld_q    <= '0;
            m_rd_q    <= '0;
            m_res_q   <= '0;
            m_pc_q    <= '0;
            w_valid_q <= '0;
            w_wen_q   <= '0;
            w_rd      <= '0;
            w_data    <= '0;
            w_pc      <= '0;
        end else if (!hold) begin
            m_valid_q <= flush ? '0 : e_valid;
            m_wen_q   <= e_wen;
            m_ld_q    <= e_ld;
            m_rd_q    <= e_rd;
            m_res_q   <= e_res;
            m_pc_q    <= e_pc;
            w_valid_q <= m_valid_q;
            w_wen_q   <= m_wen_q;
            w_rd      <= m_rd_q;
            w_data    <= m_data;
            w_pc      <= m_pc_q;
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [RF_AW-1:0] rs;
        logic [LANES-1:0] e_hit, e_ld_hit, m_hit, w_hit;

        assign rs = d_rs[s*RF_AW +: RF_AW];

        // Keep masks already exclude rd==0, so r0 never hits and falls through to RF data.
        always_comb begin
            e_hit    = '0;
            e_ld_hit = '0;
            m_hit    = '0;
            w_hit    = '0;
            for (int i = 0; i < LANES; i++) begin
                e_hit[i]    = e_keep[i] & ~e_ld[i] & (e_rd[i*RF_AW +: RF_AW] == rs);
                e_ld_hit[i] = e_keep[i] & e_ld[i] & (e_rd[i*RF_AW +: RF_AW] == rs);
                m_hit[i]    = m_keep[i] & (m_rd_q[i*RF_AW +: RF_AW] == rs);
                w_hit[i]    = w_keep[i] & (w_rd[i*RF_AW +: RF_AW] == rs);
            end
        end

        assign stall_src[s] = |e_ld_hit;

        cpu7_exu_byp_mux #(
            .GRLEN(GRLEN),
            .LANES(LANES)
        ) u_mux (
            .e_hit  (e_hit),
            .e_data (e_res),
            .m_hit  (m_hit),
            .m_data (m_data),
            .w_hit  (w_hit),
            .w_data (w_data),
            .rf_data(d_rf_data[s*GRLEN +: GRLEN]),
            .op_data(d_op_data[s*GRLEN +: GRLEN])
        );
    end

    assign d_stall = |stall_src;

endmodule

// File: tb/tb_cpu7_exu_byp.sv
// Self-checking bench for cpu7_exu_byp: directed forwarding/interlock cases plus a scoreboarded W stream.
module tb_cpu7_exu_byp;

    logic         clk = 1'b0;
    logic         resetn;
    logic         hold, flush;
    logic [1:0]   e_valid, e_wen, e_ld;
    logic [9:0]   e_rd;
    logic [63:0]  e_res, e_pc, m_ld_data;
    logic [19:0]  d_rs;
    logic [127:0] d_rf_data, d_op_data;
    logic         d_stall;
    logic [1:0]   w_wen;
    logic [9:0]   w_rd;
    logic [63:0]  w_data, w_pc;

    typedef struct packed {
        logic [1:0]  valid;
        logic [1:0]  wen;
        logic [1:0]  ld;
        logic [9:0]  rd;
        logic [63:0] res;
        logic [63:0] pc;
    } ent_t;

    typedef struct packed {
        logic [1:0]  wen;
        logic [9:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
    } wb_t;

    ent_t pipe_q[$];
    wb_t  exp_w;
    int   n_tests = 0;
    int   n_fail  = 0;

    cpu7_exu_byp #(
        .GRLEN(32),
        .LANES(2),
        .RF_AW(5)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .hold     (hold),
        .flush    (flush),
        .e_valid  (e_valid),
        .e_wen    (e_wen),
        .e_ld     (e_ld),
        .e_rd     (e_rd),
        .e_res    (e_res),
        .e_pc     (e_pc),
        .m_ld_data(m_ld_data),
        .d_rs     (d_rs),
        .d_rf_data(d_rf_data),
        .d_op_data(d_op_data),
        .d_stall  (d_stall),
        .w_wen    (w_wen),
        .w_rd     (w_rd),
        .w_data   (w_data),
        .w_pc     (w_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] op(input int s);
        return 64'(d_op_data[s*32 +: 32]);
    endfunction

    task automatic set_e(input int l, input logic v, input logic w, input logic ld,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
        e_valid[l]       = v;
        e_wen[l]         = w;
        e_ld[l]          = ld;
        e_rd[l*5 +: 5]   = rd;
        e_res[l*32 +: 32] = res;
        e_pc[l*32 +: 32]  = pc;
    endtask

    task automatic clear_e();
        e_valid = '0;
        e_wen   = '0;
        e_ld    = '0;
        e_rd    = '0;
        e_res   = '0;
        e_pc    = '0;
    endtask

    task automatic set_rs(input int s, input logic [4:0] rs);
        d_rs[s*5 +: 5] = rs;
    endtask

    // One clock: the M entry becomes the expected W (load data bound now), E is pushed as new M.
    task automatic tick();
        ent_t m, nxt;
        logic e0, e1;
        if (!hold) begin
            if (pipe_q.size() == 0) begin
                $display("FAIL scoreboard: got empty queue expected one entry");
                n_fail++;
            end else begin
                m = pipe_q.pop_front();
                e0 = m.valid[0] & m.wen[0] & (m.rd[4:0] != 5'd0);
                e1 = m.valid[1] & m.wen[1] & (m.rd[9:5] != 5'd0);
                exp_w.wen  = {e1, e0 & ~(e1 & (m.rd[4:0] == m.rd[9:5]))};
                exp_w.rd   = m.rd;
                exp_w.data = {m.ld[1] ? m_ld_data[63:32] : m.res[63:32],
                              m.ld[0] ? m_ld_data[31:0]  : m.res[31:0]};
                exp_w.pc   = m.pc;
            end
            nxt.valid = flush ? 2'b00 : e_valid;
            nxt.wen   = e_wen;
            nxt.ld    = e_ld;
            nxt.rd    = e_rd;
            nxt.res   = e_res;
            nxt.pc    = e_pc;
            pipe_q.push_back(nxt);
        end
        @(posedge clk);
        #1;
        check_eq("w_wen", 64'(w_wen), 64'(exp_w.wen));
        check_eq("w_rd", 64'(w_rd), 64'(exp_w.rd));
        check_eq("w_data", w_data, exp_w.data);
        check_eq("w_pc", w_pc, exp_w.pc);
        @(negedge clk);
    endtask

    initial begin
        resetn    = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        clear_e();
        set_e(0, 1'b1, 1'b1, 1'b0, 5'd1, 32'h1111, 32'h10);
        set_e(1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h2222, 32'h14);
        m_ld_data = '0;
        d_rs      = {4{5'd30}};
        d_rf_data = {4{32'hDEAD}};

        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("rst_w_wen", 64'(w_wen), 64'd0);
            check_eq("rst_w_data", w_data, 64'd0);
            check_eq("rst_w_pc", w_pc, 64'd0);
            check_eq("rst_d_stall", 64'(d_stall), 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        clear_e();
        pipe_q.delete();
        pipe_q.push_back('0);
        exp_w = '0;

        // E-stage forward, then M, then W
        set_e(0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h100);
        set_rs(2, 5'd5);
        #1;
        check_eq("fwd_e", op(2), 64'h1234);
        check_eq("fwd_e_stall", 64'(d_stall), 64'd0);
        tick();
        clear_e();
        #1;
        check_eq("fwd_m", op(2), 64'h1234);
        tick();
        check_eq("wb_lat_wen", 64'(w_wen), 64'b01);
        check_eq("wb_lat_data", 64'(w_data[31:0]), 64'h1234);
        check_eq("fwd_w", op(2), 64'h1234);
        tick();
        check_eq("fwd_none", op(2), 64'hDEAD);
        set_rs(2, 5'd30);

        // Youngest lane wins
        set_e(0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h11, 32'h200);
        set_e(1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h22, 32'h204);
        set_rs(0, 5'd7);
        #1;
        check_eq("young_fwd", op(0), 64'h22);
        check_eq("young_other", op(1), 64'hDEAD);
        tick();
        clear_e();
        tick();
        check_eq("young_w_wen", 64'(w_wen), 64'b10);
        check_eq("young_w_data", 64'(w_data[63:32]), 64'h22);
        tick();
        set_rs(0, 5'd30);

        // Load-use interlock, then load data via M
        set_e(0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hBAD, 32'h300);
        set_rs(1, 5'd3);
        #1;
        check_eq("ld_stall", 64'(d_stall), 64'd1);
        tick();
        clear_e();
        m_ld_data[31:0] = 32'hCAFE;
        #1;
        check_eq("ld_nostall", 64'(d_stall), 64'd0);
        check_eq("ld_fwd_m", op(1), 64'hCAFE);
        tick();
        check_eq("ld_w_data", 64'(w_data[31:0]), 64'hCAFE);
        tick();

        // Older load overwritten by younger ALU result: no stall
        set_e(0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hBAD, 32'h310);
        set_e(1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'h314);
        #1;
        check_eq("ld_ovr_stall", 64'(d_stall), 64'd0);
        check_eq("ld_ovr_fwd", op(1), 64'h33);
        tick();
        clear_e();
        tick();

        // Younger lane load shadows older ALU result: stall
        set_e(0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h44, 32'h320);
        set_e(1, 1'b1, 1'b1, 1'b1, 5'd3, 32'hBAD, 32'h324);
        #1;
        check_eq("ld_young_stall", 64'(d_stall), 64'd1);
        tick();
        clear_e();
        m_ld_data[63:32] = 32'hBEEF;
        #1;
        check_eq("ld_young_fwd", op(1), 64'hBEEF);
        tick();
        tick();
        set_rs(1, 5'd30);

        // Register 0
        set_e(0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFF, 32'h400);
        set_rs(3, 5'd0);
        d_rf_data[3*32 +: 32] = 32'h55;
        #1;
        check_eq("r0_fwd", op(3), 64'h55);
        tick();
        clear_e();
        #1;
        check_eq("r0_fwd_m", op(3), 64'h55);
        tick();
        check_eq("r0_w_wen", 64'(w_wen), 64'd0);
        tick();

        // hold with flush: W frozen; flushed E never reaches W, older M still does
        set_e(0, 1'b1, 1'b1, 1'b0, 5'd10, 32'hA1, 32'h500);
        tick();
        clear_e();
        set_e(1, 1'b1, 1'b1, 1'b0, 5'd11, 32'hB2, 32'h504);
        hold  = 1'b1;
        flush = 1'b1;
        tick();
        tick();
        check_eq("hold_w_wen", 64'(w_wen), 64'd0);
        hold = 1'b0;
        tick();
        check_eq("flush_m_wb", 64'(w_wen), 64'b01);
        check_eq("flush_m_data", 64'(w_data[31:0]), 64'hA1);
        flush = 1'b0;
        clear_e();
        tick();
        check_eq("flush_e_gone", 64'(w_wen), 64'd0);

        // Random stream through the scoreboard
        for (int n = 0; n < 80; n++) begin
            hold      = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 5) == 0);
            e_valid   = 2'($urandom_range(0, 3));
            e_wen     = 2'($urandom_range(0, 3));
            e_ld      = 2'($urandom_range(0, 3));
            e_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            e_res     = {$urandom(), $urandom()};
            e_pc      = {$urandom(), $urandom()};
            m_ld_data = {$urandom(), $urandom()};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
